// File: rtl/ex_issue_stage.sv
// Two-entry in-order issue buffer (head + skid) between decode and the ALU.
// Captures forwarded operands and keeps snooping the MEM/WB buses while entries wait.
module ex_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [XLEN-1:0] dec_rs1_val,
  input  logic [XLEN-1:0] dec_rs2_val,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic [8:0]      dec_ctrl,
  input  logic [4:0]      dec_rd,
  input  logic            dec_rd_we,
  input  logic            fwd_mem_valid,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y,
  output logic [8:0]      ex_ctrl,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we
);

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_imm;
    logic [8:0]      ctrl;
    logic [4:0]      rd;
    logic            rd_we;
  } entry_t;

  entry_t head, skid, head_s, skid_s, new_e, head_n, skid_n;
  logic   head_v, skid_v, head_v_n, skid_v_n;
  logic   push, pop;

  // Register 0 always reads as zero; MEM result is younger than WB, so it wins.
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] dflt,
    input logic            mv,
    input logic [4:0]      mrd,
    input logic [XLEN-1:0] md,
    input logic            wv,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wd
  );
    if (idx == 5'd0)              return '0;
    else if (mv && (mrd == idx))  return md;
    else if (wv && (wrd == idx))  return wd;
    else                          return dflt;
  endfunction

  function automatic entry_t snoop(
    input entry_t          e,
    input logic            mv,
    input logic [4:0]      mrd,
    input logic [XLEN-1:0] md,
    input logic            wv,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wd
  );
    entry_t r;
    r   = e;
    r.x = fwd(e.rs1, e.x, mv, mrd, md, wv, wrd, wd);
    if (!e.use_imm) r.y = fwd(e.rs2, e.y, mv, mrd, md, wv, wrd, wd);
    return r;
  endfunction

  assign push = dec_valid && dec_ready;
  assign pop  = head_v && ex_ready;

  always_comb begin
    new_e         = '0;
    new_e.rs1     = dec_rs1;
    new_e.rs2     = dec_rs2;
    new_e.use_imm = dec_use_imm;
    new_e.ctrl    = dec_ctrl;
    new_e.rd      = dec_rd;
    new_e.rd_we   = dec_rd_we;
    new_e.x = fwd(dec_rs1, dec_rs1_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                  fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    new_e.y = dec_use_imm ? dec_imm :
              fwd(dec_rs2, dec_rs2_val, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                  fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

    head_s = snoop(head, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    skid_s = snoop(skid, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

    head_n   = head_s;
    skid_n   = skid_s;
    head_v_n = head_v;
    skid_v_n = skid_v;

    // Skid only fills while head is stalled; it drains into head on the next pop.
    if (pop && skid_v) begin
      head_n   = skid_s;
      head_v_n = 1'b1;
      skid_v_n = 1'b0;
    end else if (pop || !head_v) begin
      head_n   = push ? new_e : head_s;
      head_v_n = push;
      skid_v_n = 1'b0;
    end else if (push) begin
      skid_n   = new_e;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      skid      <= '0;
      head_v    <= 1'b0;
      skid_v    <= 1'b0;
      dec_ready <= 1'b1;
    end else if (flush) begin
      head_v    <= 1'b0;
      skid_v    <= 1'b0;
      dec_ready <= 1'b1;
    end else begin
      head      <= head_n;
      skid      <= skid_n;
      head_v    <= head_v_n;
      skid_v    <= skid_v_n;
      dec_ready <= !skid_v_n;
    end
  end

  assign ex_valid = head_v;
  assign x        = head.x;
  assign y        = head.y;
  assign ex_ctrl  = head.ctrl;
  assign ex_rd    = head.rd;
  assign ex_rd_we = head.rd_we;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed self-checking bench for ex_issue_stage with hand-computed expectations.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, dec_valid, dec_ready, dec_use_imm, dec_rd_we;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm;
  logic [8:0]  dec_ctrl;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        ex_valid, ex_ready, ex_rd_we;
  logic [31:0] x, y;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_ctrl(dec_ctrl),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .x(x), .y(y), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic use_imm,
                               input logic [8:0] ctrl, input logic [4:0] rd, input logic we);
    dec_valid   = v;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_rs1_val = v1;
    dec_rs2_val = v2;
    dec_imm     = imm;
    dec_use_imm = use_imm;
    dec_ctrl    = ctrl;
    dec_rd      = rd;
    dec_rd_we   = we;
  endtask

  task automatic setFwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    fwd_mem_valid = mv; fwd_mem_rd = mrd; fwd_mem_data = md;
    fwd_wb_valid  = wv; fwd_wb_rd  = wrd; fwd_wb_data  = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ex_valid"}, {31'b0, ex_valid}, 32'd0);
    checkOutput({tag, "_dec_ready"}, {31'b0, dec_ready}, 32'd1);
    checkOutput({tag, "_x"}, x, 32'd0);
    checkOutput({tag, "_y"}, y, 32'd0);
    checkOutput({tag, "_ctrl"}, {23'b0, ex_ctrl}, 32'd0);
    checkOutput({tag, "_rd"}, {27'b0, ex_rd}, 32'd0);
    checkOutput({tag, "_rd_we"}, {31'b0, ex_rd_we}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    step(); step();
    checkReset("reset");
    rst_n = 1'b1;

    // Pass-through ADD
    ex_ready = 1'b1;
    applyStimulus(1, 5'd1, 5'd2, 32'd10, 32'd5, 32'd0, 0, 9'h000, 5'd4, 1);
    step();
    checkOutput("pt_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("pt_x", x, 32'd10);
    checkOutput("pt_y", y, 32'd5);
    checkOutput("pt_rd", {27'b0, ex_rd}, 32'd4);
    checkOutput("pt_rd_we", {31'b0, ex_rd_we}, 32'd1);
    checkOutput("pt_alu", x + y, 32'd15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    step();
    checkOutput("pt_drain", {31'b0, ex_valid}, 32'd0);

    // Forwarding priority at capture
    setFwd(1, 5'd3, 32'h7FFF_FFFF, 1, 5'd3, 32'd1);
    applyStimulus(1, 5'd3, 5'd4, 32'h55, 32'h66, 32'h100, 1, 9'h001, 5'd5, 1);
    step();
    checkOutput("fwd_mem_over_wb", x, 32'h7FFF_FFFF);
    checkOutput("fwd_imm_y", y, 32'h100);
    setFwd(1, 5'd6, 32'h999, 1, 5'd5, 32'hABC);
    applyStimulus(1, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 0, 9'h002, 5'd6, 1);
    step();
    checkOutput("fwd_wb_x", x, 32'hABC);
    checkOutput("fwd_mem_y", y, 32'h999);
    checkOutput("fwd_pushpop_ctrl", {23'b0, ex_ctrl}, 32'h002);
    setFwd(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678);
    applyStimulus(1, 5'd0, 5'd9, 32'h77, 32'h99, 32'h0, 0, 9'h003, 5'd7, 1);
    step();
    checkOutput("fwd_r0_x", x, 32'd0);
    checkOutput("fwd_nomatch_y", y, 32'h99);
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    step();
    checkOutput("fwd_drain", {31'b0, ex_valid}, 32'd0);

    // Backpressure: A then B, C refused while full
    ex_ready = 1'b0;
    applyStimulus(1, 5'd1, 5'd2, 32'hA1, 32'hA2, 0, 0, 9'h011, 5'd10, 1);
    step();
    checkOutput("bp_a_valid", {31'b0, ex_valid}, 32'd1);
    checkOutput("bp_a_ready", {31'b0, dec_ready}, 32'd1);
    applyStimulus(1, 5'd1, 5'd2, 32'hB1, 32'hB2, 0, 0, 9'h022, 5'd11, 1);
    step();
    checkOutput("bp_full_ready", {31'b0, dec_ready}, 32'd0);
    checkOutput("bp_hold_x", x, 32'hA1);
    applyStimulus(1, 5'd1, 5'd2, 32'hC1, 32'hC2, 0, 0, 9'h033, 5'd12, 1);
    step();
    checkOutput("bp_still_full", {31'b0, dec_ready}, 32'd0);
    checkOutput("bp_hold_rd", {27'b0, ex_rd}, 32'd10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    ex_ready = 1'b1;
    step();
    checkOutput("bp_b_x", x, 32'hB1);
    checkOutput("bp_b_y", y, 32'hB2);
    checkOutput("bp_b_ctrl", {23'b0, ex_ctrl}, 32'h022);
    checkOutput("bp_b_rd", {27'b0, ex_rd}, 32'd11);
    checkOutput("bp_reopen", {31'b0, dec_ready}, 32'd1);
    step();
    checkOutput("bp_no_dup", {31'b0, ex_valid}, 32'd0);

    // Snoop while stalled
    ex_ready = 1'b0;
    applyStimulus(1, 5'd8, 5'd7, 32'h8, 32'h1, 0, 0, 9'h004, 5'd1, 1);
    step();
    checkOutput("snp_init_y", y, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    setFwd(1, 5'd8, 32'h800, 1, 5'd7, 32'hDEAD_BEEF);
    step();
    checkOutput("snp_wb_y", y, 32'hDEAD_BEEF);
    checkOutput("snp_mem_x", x, 32'h800);
    setFwd(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("snp_keep_y", y, 32'hDEAD_BEEF);
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    setFwd(1, 5'd7, 32'h777, 1, 5'd7, 32'hDEAD_BEEF);
    applyStimulus(1, 5'd0, 5'd7, 0, 32'h1, 32'h42, 1, 9'h005, 5'd2, 1);
    step();
    checkOutput("snp_imm_cap", y, 32'h42);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    step();
    checkOutput("snp_imm_keep", y, 32'h42);
    setFwd(0, 0, 0, 0, 0, 0);

    // Flush while full with a simultaneous offer
    applyStimulus(1, 5'd1, 5'd2, 32'hB1, 32'hB2, 0, 0, 9'h022, 5'd11, 1);
    step();
    checkOutput("fl_full", {31'b0, dec_ready}, 32'd0);
    flush = 1'b1; ex_ready = 1'b1;
    applyStimulus(1, 5'd1, 5'd2, 32'hC1, 32'hC2, 0, 0, 9'h033, 5'd12, 1);
    step();
    checkOutput("fl_valid", {31'b0, ex_valid}, 32'd0);
    checkOutput("fl_ready", {31'b0, dec_ready}, 32'd1);
    applyStimulus(1, 5'd1, 5'd2, 32'hD1, 32'hD2, 0, 0, 9'h044, 5'd13, 1);
    step();
    checkOutput("fl_drop_empty", {31'b0, ex_valid}, 32'd0);
    flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    step();
    checkOutput("fl_never_appears", {31'b0, ex_valid}, 32'd0);

    // Reset in the middle of a two-entry stall
    ex_ready = 1'b0;
    applyStimulus(1, 5'd1, 5'd2, 32'hA1, 32'hA2, 0, 0, 9'h011, 5'd10, 1);
    step();
    applyStimulus(1, 5'd1, 5'd2, 32'hB1, 32'hB2, 0, 0, 9'h022, 5'd11, 1);
    step();
    checkOutput("rs_full", {31'b0, dec_ready}, 32'd0);
    rst_n = 1'b0; flush = 1'b1;
    step();
    checkReset("rs_stall");
    rst_n = 1'b1; flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9'h0, 0, 0);
    ex_ready = 1'b1;
    step();
    checkOutput("rs_discarded", {31'b0, ex_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and data width.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  in  1  discard all held and incoming instructions.
REQ-005 SHALL have port dec_valid  in  1  decode offers an instruction.
REQ-006 SHALL have port dec_ready  out  1  stage accepts; registered output.
REQ-007 SHALL have port dec_rs1  in  5  source-1 register index.
REQ-008 SHALL have port dec_rs2  in  5  source-2 register index.
REQ-009 SHALL have port dec_rs1_val  in  XLEN  register-file value for rs1.
REQ-010 SHALL have port dec_rs2_val  in  XLEN  register-file value for rs2.
REQ-011 SHALL have port dec_imm  in  XLEN  extended immediate.
REQ-012 SHALL have port dec_use_imm  in  1  y takes dec_imm instead of rs2.
REQ-013 SHALL have port dec_ctrl  in  9  {add_sub, ConstVar, LogicFn[1:0], ShiftFn[1:0], FnClass[2:0]}.
REQ-014 SHALL have port dec_rd / dec_rd_we  in  5/1  destination index and write enable.
REQ-015 SHALL have port fwd_mem_valid / fwd_mem_rd / fwd_mem_data  in  1/5/XLEN  MEM-stage result bus.
REQ-016 SHALL have port fwd_wb_valid / fwd_wb_rd / fwd_wb_data  in  1/5/XLEN  WB-stage result bus.
REQ-017 SHALL have port ex_valid  out  1  head entry valid toward ALU.
REQ-018 SHALL have port ex_ready  in  1  ALU/EX consumer accepts.
REQ-019 SHALL have port x / y  out  XLEN  ALU operands of head entry.
REQ-020 SHALL have port ex_ctrl  out  9  head entry control, same packing as dec_ctrl.
REQ-021 SHALL have port ex_rd / ex_rd_we  out  5/1  head entry destination.

Function
REQ-022 SHALL be an in-order 2-entry buffer (head, skid); transfer in on dec_valid&&dec_ready, out on ex_valid&&ex_ready.
REQ-023 SHALL register dec_ready = NOT skid-entry valid; no combinational path from ex_ready to dec_ready.
REQ-024 SHALL deliver captured entry to x/y/ex_* the cycle after capture when buffer was empty (latency 1).
REQ-025 SHALL, on simultaneous push and pop with one entry held, keep occupancy 1 and present the new entry next cycle.
REQ-026 SHALL capture x from: 0 if dec_rs1==0; else fwd_mem_data if fwd_mem_valid && fwd_mem_rd==dec_rs1; else fwd_wb_data on WB match; else dec_rs1_val.
REQ-027 SHALL capture y as dec_imm when dec_use_imm, else rs2 selected by the REQ-026 priority.
REQ-028 SHALL, every cycle, update each held valid entry's non-immediate operands from the forwarding buses using the REQ-026 priority (MEM over WB, index 0 never forwarded).
REQ-029 SHALL make x/y outputs registered values; snooped updates visible the cycle after the bus match.
REQ-030 SHALL, on flush, invalidate both entries and drop any same-cycle input; ex_valid=0 and dec_ready=1 next cycle; flush dominates push/pop.
REQ-031 SHALL hold head contents stable while ex_valid && !ex_ready, except REQ-028 snoop updates.
REQ-032 SHALL pass ex_ctrl, ex_rd, ex_rd_we through unchanged from capture.

Reset
REQ-033 SHALL, with rst_n low at a clock edge, set ex_valid=0, dec_ready=1, x=y=0, ex_ctrl=0, ex_rd=0, ex_rd_we=0; reset dominates flush.
REQ-034 SHALL discard in-flight entries if rst_n asserts mid-stall.

Verification
REQ-035 SHALL verify pass-through: rs1_val=10, rs2_val=5, ctrl ADD, ex_ready=1 -> next cycle ex_valid=1, x=10, y=5; ALU returns 15.
REQ-036 SHALL verify forwarding priority: rs1=3, MEM rd=3 data=0x7FFFFFFF, WB rd=3 data=1 -> x=0x7FFFFFFF; rs1=0 with MEM rd=0 -> x=0.
REQ-037 SHALL verify backpressure: ex_ready=0, push A then B -> dec_ready=0 after B; ex_ready=1 -> A then B in order, no loss or duplication.
REQ-038 SHALL verify snoop: held entry rs2=7 stalled, WB rd=7 data=0xDEADBEEF -> y=0xDEADBEEF next cycle; with dec_use_imm=1 y keeps imm.
REQ-039 SHALL verify flush with simultaneous push while full -> ex_valid=0, dec_ready=1 next cycle, pushed entry never appears.
REQ-040 SHALL verify rst_n low during stall with 2 entries -> all outputs at REQ-033 values next cycle.
